// File: rtl/vga_timing_generator.sv
// Raster timing for the VGA path: column/row counters, display enable, syncs, frame pulse/count.
// Define VGA_SYNC_ALIGN_EN to delay hsync/vsync one pixel step to line up with registered RGB.
module vga_timing_generator #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0
) (
    input  logic        vga_clock,
    input  logic        reset,
    input  logic        pixel_enable,
    output logic [31:0] column,
    output logic [31:0] row,
    output logic        display_enable,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [31:0] H_LAST    = 32'(H_TOTAL - 1);
    localparam logic [31:0] V_LAST    = 32'(V_TOTAL - 1);
    localparam logic [31:0] H_VIS     = 32'(H_VISIBLE);
    localparam logic [31:0] V_VIS     = 32'(V_VISIBLE);
    localparam logic [31:0] HS_START  = 32'(H_VISIBLE + H_FRONT);
    localparam logic [31:0] HS_END    = 32'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [31:0] VS_START  = 32'(V_VISIBLE + V_FRONT);
    localparam logic [31:0] VS_END    = 32'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [31:0] r_column;
    logic [31:0] r_row;
    logic        r_display_enable;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_frame_start;
    logic [15:0] r_frame_count;

    logic [31:0] w_next_col;
    logic [31:0] w_next_row;
    logic        w_de_next;
    logic        w_hs_next;
    logic        w_vs_next;
    logic        w_fs_next;

    // Every flag is derived from the next position so it registers alongside it.
    always_comb begin
        w_next_col = r_column + 32'd1;
        w_next_row = r_row;
        if (r_column == H_LAST) begin
            w_next_col = 32'd0;
            w_next_row = (r_row == V_LAST) ? 32'd0 : r_row + 32'd1;
        end
        w_de_next = (w_next_col < H_VIS) && (w_next_row < V_VIS);
        w_hs_next = ((w_next_col >= HS_START) && (w_next_col < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
        w_vs_next = ((w_next_row >= VS_START) && (w_next_row < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
        w_fs_next = (w_next_col == 32'd0) && (w_next_row == 32'd0);
    end

    // Reset parks on the last raster position so the first step lands on (0,0).
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            r_column         <= H_LAST;
            r_row            <= V_LAST;
            r_display_enable <= 1'b0;
            r_hsync          <= ~H_SYNC_POL;
            r_vsync          <= ~V_SYNC_POL;
            r_frame_start    <= 1'b0;
            r_frame_count    <= 16'd0;
        end else if (pixel_enable) begin
            r_column         <= w_next_col;
            r_row            <= w_next_row;
            r_display_enable <= w_de_next;
            r_hsync          <= w_hs_next;
            r_vsync          <= w_vs_next;
            r_frame_start    <= w_fs_next;
            if (w_fs_next) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    logic r_hsync_d;
    logic r_vsync_d;

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            r_hsync_d <= ~H_SYNC_POL;
            r_vsync_d <= ~V_SYNC_POL;
        end else if (pixel_enable) begin
            r_hsync_d <= r_hsync;
            r_vsync_d <= r_vsync;
        end
    end

    assign hsync = r_hsync_d;
    assign vsync = r_vsync_d;
`else
    assign hsync = r_hsync;
    assign vsync = r_vsync;
`endif

    assign column         = r_column;
    assign row            = r_row;
    assign display_enable = r_display_enable;
    assign frame_start    = r_frame_start;
    assign frame_count    = r_frame_count;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Scoreboard bench: default 640x480 instance plus a tiny-raster instance (active-high syncs)
// so whole frames fit in a short run. Honours VGA_SYNC_ALIGN_EN in its reference model.
module tb_vga_timing_generator;

    logic vga_clock = 1'b0;
    logic reset = 1'b0;
    logic pixel_enable = 1'b0;

    always #5 vga_clock = ~vga_clock;

    logic [31:0] a_column, a_row, b_column, b_row;
    logic        a_de, a_hs, a_vs, a_fs, b_de, b_hs, b_vs, b_fs;
    logic [15:0] a_fc, b_fc;

    vga_timing_generator dut_a (
        .vga_clock(vga_clock), .reset(reset), .pixel_enable(pixel_enable),
        .column(a_column), .row(a_row), .display_enable(a_de),
        .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs), .frame_count(a_fc)
    );

    vga_timing_generator #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
    ) dut_b (
        .vga_clock(vga_clock), .reset(reset), .pixel_enable(pixel_enable),
        .column(b_column), .row(b_row), .display_enable(b_de),
        .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs), .frame_count(b_fc)
    );

    typedef struct {
        int hv, hf, hs, ht, vv, vf, vs, vt;
        bit hpol, vpol;
        int col, row;
        bit de, hsy, vsy, fs, hraw, vraw;
        logic [15:0] fc;
    } mdl_t;

    function automatic mdl_t mdl_reset(mdl_t m);
        m.col  = m.ht - 1;
        m.row  = m.vt - 1;
        m.de   = 1'b0;
        m.fs   = 1'b0;
        m.fc   = 16'd0;
        m.hsy  = !m.hpol;
        m.vsy  = !m.vpol;
        m.hraw = m.hsy;
        m.vraw = m.vsy;
        return m;
    endfunction

    function automatic mdl_t mdl_init(int hv, int hf, int hs, int hb, int vv, int vf, int vs, int vb,
                                      bit hpol, bit vpol);
        mdl_t m;
        m.hv = hv; m.hf = hf; m.hs = hs; m.ht = hv + hf + hs + hb;
        m.vv = vv; m.vf = vf; m.vs = vs; m.vt = vv + vf + vs + vb;
        m.hpol = hpol; m.vpol = vpol;
        return mdl_reset(m);
    endfunction

    function automatic mdl_t mdl_step(mdl_t m);
        bit nh, nv;
        if (m.col == m.ht - 1) begin
            m.col = 0;
            m.row = (m.row == m.vt - 1) ? 0 : m.row + 1;
        end else begin
            m.col = m.col + 1;
        end
        m.de = (m.col < m.hv) && (m.row < m.vv);
        m.fs = (m.col == 0) && (m.row == 0);
        if (m.fs) m.fc = m.fc + 16'd1;
        nh = (m.col >= m.hv + m.hf && m.col < m.hv + m.hf + m.hs) ? m.hpol : !m.hpol;
        nv = (m.row >= m.vv + m.vf && m.row < m.vv + m.vf + m.vs) ? m.vpol : !m.vpol;
`ifdef VGA_SYNC_ALIGN_EN
        m.hsy = m.hraw;
        m.vsy = m.vraw;
`else
        m.hsy = nh;
        m.vsy = nv;
`endif
        m.hraw = nh;
        m.vraw = nv;
        return m;
    endfunction

    mdl_t ma, mb;
    mdl_t qa[$];
    mdl_t qb[$];

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: outputs settle after the rising edge; compare on the falling edge.
    always @(negedge vga_clock) begin
        mdl_t ea, eb;
        if (qa.size() != 0 && qb.size() != 0) begin
            ea = qa.pop_front();
            eb = qb.pop_front();
            chk32("a_column", a_column, ea.col);
            chk32("a_row", a_row, ea.row);
            chk1("a_display_enable", a_de, ea.de);
            chk1("a_hsync", a_hs, ea.hsy);
            chk1("a_vsync", a_vs, ea.vsy);
            chk1("a_frame_start", a_fs, ea.fs);
            chk32("a_frame_count", {16'd0, a_fc}, {16'd0, ea.fc});
            chk32("b_column", b_column, eb.col);
            chk32("b_row", b_row, eb.row);
            chk1("b_display_enable", b_de, eb.de);
            chk1("b_hsync", b_hs, eb.hsy);
            chk1("b_vsync", b_vs, eb.vsy);
            chk1("b_frame_start", b_fs, eb.fs);
            chk32("b_frame_count", {16'd0, b_fc}, {16'd0, eb.fc});
        end
    end

    int cnt_a_de, cnt_a_hs, cnt_b_de, cnt_b_hs, cnt_b_vs;

    task automatic clear_counts();
        cnt_a_de = 0; cnt_a_hs = 0; cnt_b_de = 0; cnt_b_hs = 0; cnt_b_vs = 0;
    endtask

    task automatic step(input bit pe);
        pixel_enable = pe;
        @(posedge vga_clock);
        #1;
        if (pe && reset) begin
            ma = mdl_step(ma);
            mb = mdl_step(mb);
            if (a_de) cnt_a_de++;
            if (!a_hs) cnt_a_hs++;
            if (b_de) cnt_b_de++;
            if (b_hs) cnt_b_hs++;
            if (b_vs) cnt_b_vs++;
        end
        qa.push_back(ma);
        qb.push_back(mb);
    endtask

    // Asynchronous reset between edges with pixel_enable held high.
    task automatic async_reset();
        pixel_enable = 1'b1;
        @(posedge vga_clock);
        #2;
        reset = 1'b0;
        #1;
        ma = mdl_reset(ma);
        mb = mdl_reset(mb);
        qa.push_back(ma);
        qb.push_back(mb);
    endtask

    initial begin
        logic [31:0] col_before;
        ma = mdl_init(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
        mb = mdl_init(8, 2, 3, 2, 6, 1, 2, 2, 1'b1, 1'b1);
        clear_counts();

        // Reset held: pixel_enable pulses must not move anything.
        step(0); step(1); step(1); step(0); step(1);
        reset = 1'b1;

        // First step lands on (0,0); run one small frame, then finish line 0 of the default raster.
        step(1);
        repeat (164) step(1);
        chk32("b_frame_de_count", cnt_b_de, 48);
        chk32("b_frame_hsync_count", cnt_b_hs, 33);
        chk32("b_frame_vsync_count", cnt_b_vs, 30);
        step(1);
        chk1("b_wrap_frame_start", b_fs, 1'b1);
        chk32("b_wrap_frame_count", {16'd0, b_fc}, 32'd2);
        repeat (634) step(1);
        chk32("a_line0_de_count", cnt_a_de, 640);
        chk32("a_line0_hsync_count", cnt_a_hs, 96);
        chk32("a_line0_end_col", a_column, 32'd799);
        step(1);
        chk32("a_line1_row", a_row, 32'd1);

        // Gapped enables advance exactly two positions.
        col_before = a_column;
        step(1); step(0); step(0); step(1);
        chk32("a_gapped_advance", a_column - col_before, 32'd2);

        repeat (298) step(1);
        chk32("a_pre_reset_col", a_column, 32'd300);
        async_reset();
        step(1);
        reset = 1'b1;
        step(1);
        chk32("a_restart_col", a_column, 32'd0);
        chk32("a_restart_row", a_row, 32'd0);
        step(1); step(1);

        for (int i = 0; i < 10 && qa.size() != 0; i++) @(negedge vga_clock);
        #1;
        chk32("scoreboard_drained", qa.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
Produces raster timing for the VGA path: pixel column/row counters, display enable, horizontal/vertical sync, frame-start pulse and frame counter. Drives the row, column and display_enable inputs of the colour-output stage, and drives the monitor sync pins directly. Default timing is 640x480 @ 60 Hz with one pixel per pixel_enable step.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
H_SYNC_POL, 0, active level of hsync
V_SYNC_POL, 0, active level of vsync

Ports:
vga_clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
pixel_enable  in  1  advance raster one pixel on this vga_clock edge
column  out  32 (int)  current horizontal position, 0..H_TOTAL-1
row  out  32 (int)  current vertical position, 0..V_TOTAL-1
display_enable  out  1  high when column<H_VISIBLE and row<V_VISIBLE
hsync  out  1  horizontal sync, active level H_SYNC_POL
vsync  out  1  vertical sync, active level V_SYNC_POL
frame_start  out  1  one-step pulse at position (0,0)
frame_count  out  16  frames started since reset

Behaviour:
- Derived values: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
- All outputs are registered and updated only on vga_clock rising edges where pixel_enable=1. With pixel_enable=0, every output holds, including frame_start.
- Reset (async, active-low) loads the following values:
  - column=H_TOTAL-1 (799), row=V_TOTAL-1 (524)
  - display_enable=0, frame_start=0, frame_count=0
  - hsync=!H_SYNC_POL, vsync=!V_SYNC_POL
- The reset position is the last raster position, so the first advance after release lands on (0,0).
- Advance:
  - column increments by 1.
  - At column=H_TOTAL-1, column wraps to 0 and row increments by 1.
  - At (H_TOTAL-1, V_TOTAL-1), both counters wrap to 0.
- display_enable, hsync, vsync and frame_start are computed from the next position and registered together with it. All outputs therefore describe the same position with zero relative latency.
- hsync is active for H_VISIBLE+H_FRONT <= column < H_VISIBLE+H_FRONT+H_SYNC (656..751).
- vsync is active for V_VISIBLE+V_FRONT <= row < V_VISIBLE+V_FRONT+V_SYNC (490..491), across whole lines, independent of column.
- frame_start=1 exactly for the step at which the position becomes (0,0); otherwise 0.
- frame_count increments on the same step frame_start asserts, so it reads 1 during the first frame after reset. It wraps 65535 -> 0.
- Reset asserted mid-frame returns all outputs to their reset values immediately, regardless of pixel_enable. After release, the raster restarts from (0,0).
- pixel_enable continuously 1 gives one pixel per vga_clock cycle.

Optional Feature:
VGA_SYNC_ALIGN_EN:
- Defined: hsync and vsync pass through one extra register stage, clocked on pixel_enable steps. Sync then lags column/row/display_enable by one step, matching the colour-output stage's one-cycle registered RGB.
  - The extra stage resets to the inactive level.
  - The hsync active window observed against column becomes 657..752; wraps are handled naturally.
- Undefined: sync is aligned with column/row as specified above.

Test Plan:
1. Hold reset low, pulse pixel_enable -> column=799, row=524, display_enable=0, hsync=1, vsync=1, frame_count=0; all stay constant.
2. Release reset, one pixel_enable step -> column=0, row=0, display_enable=1, frame_start=1, frame_count=1. Next step -> column=1, frame_start=0.
3. Run line 0 continuously -> display_enable falls at column 640; hsync=0 for exactly 96 steps (columns 656..751); at 799->0, row becomes 1.
4. Run 420000 steps from (0,0):
   - vsync=0 for exactly 1600 steps (rows 490..491).
   - display_enable=1 for exactly 307200 steps.
   - The step that returns to (0,0) pulses frame_start and sets frame_count=2.
5. Toggle pixel_enable 1,0,0,1 -> outputs advance exactly two positions. Assert reset at (300,200) -> immediate reset values; release -> first step gives (0,0).
6. With VGA_SYNC_ALIGN_EN defined -> hsync=0 while column=657..752; after reset, the first hsync falling edge occurs one step after column=656.
